trigger_recorder: RTL and testbench

TRIGGER_RECORDER -- requirements
Module: trigger_recorder

---
 rtl/trigger_recorder.sv | 164 ++++++++++++++++
 tb/tb_trigger_recorder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_recorder.sv
// trigger_recorder
//   Timestamps trigger-decoder pulses and queues them as records in a
//   first-word-fall-through FIFO for a downstream consumer.
//
//   Record layout: {type[1:0], evt_num[EVT_W-1:0], timestamp[TS_W-1:0]}
//     type 2'b00 = L1A, 2'b01 = pseudo-L1A, 2'b10 = delta
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   l1a        L1 accept pulse (pushes a record, advances evt_num)
//   pl1a       pseudo-L1A pulse (pushes a record)
//   align      align pulse (zeroes timestamp and evt_num, no record)
//   delta      delta pulse (pushes a record)
//   rd_en      consumer pop request
//   rec_valid  FIFO holds at least one record, rec_data is valid
//   rec_data   oldest record in the FIFO (zero when empty)
//   fifo_full  FIFO holds 2^AW records
//   ovf_cnt    saturating count of records dropped because the FIFO was full
//   evt_num    current event number
module trigger_recorder #(
  parameter int TS_W  = 32,
  parameter int EVT_W = 24,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    l1a,
  input  logic                    pl1a,
  input  logic                    align,
  input  logic                    delta,
  input  logic                    rd_en,
  output logic                    rec_valid,
  output logic [2+EVT_W+TS_W-1:0] rec_data,
  output logic                    fifo_full,
  output logic [15:0]             ovf_cnt,
  output logic [EVT_W-1:0]        evt_num
);

  localparam int RW    = 2 + EVT_W + TS_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    REC_L1A   = 2'b00,
    REC_PL1A  = 2'b01,
    REC_DELTA = 2'b10
  } rec_type_t;

  logic [TS_W-1:0] timestamp;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [RW-1:0]   mem [DEPTH];

  logic            push_req;
  rec_type_t       push_type;
  logic            is_empty;
  logic            is_full;
  logic            push;
  logic            pop;
  logic            drop;

  // Pick the single winning trigger. Align beats everything and never
  // produces a record; among the rest l1a beats pl1a beats delta, and the
  // losers simply vanish.
  always_comb begin
    push_req  = 1'b0;
    push_type = REC_L1A;
    if (!align) begin
      if (l1a) begin
        push_req  = 1'b1;
        push_type = REC_L1A;
      end else if (pl1a) begin
        push_req  = 1'b1;
        push_type = REC_PL1A;
      end else if (delta) begin
        push_req  = 1'b1;
        push_type = REC_DELTA;
      end
    end
  end

  // FIFO handshake. A pop frees a slot at the same edge, so a full FIFO
  // still accepts a push when the consumer is reading; only an unserved
  // push into a full FIFO is a drop.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == FULL_COUNT);
    pop      = rd_en && !is_empty;
    push     = push_req && (!is_full || pop);
    drop     = push_req && is_full && !pop;
  end

  // Free-running timestamp; align restarts it so the following cycle reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timestamp <= '0;
    end else if (align) begin
      timestamp <= '0;
    end else begin
      timestamp <= timestamp + 1'b1;
    end
  end

  // Event number advances on every winning l1a, including one that gets
  // dropped on overflow, so downstream can see the gap in numbering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_num <= '0;
    end else if (align) begin
      evt_num <= '0;
    end else if (l1a) begin
      evt_num <= evt_num + 1'b1;
    end
  end

  // Record storage. It is not reset; stale contents are hidden because
  // rec_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_type, evt_num, timestamp};
    end
  end

  // Pointers wrap naturally at 2^AW; count carries the extra bit that
  // tells full apart from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dropped-record counter sticks at its maximum rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  // Fall-through head of the FIFO.
  always_comb begin
    rec_valid = !is_empty;
    fifo_full = is_full;
    rec_data  = is_empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_trigger_recorder.sv
// tb_trigger_recorder
//   Directed test of trigger_recorder. A default-sized instance covers the
//   record/FIFO behaviour; a second instance with an 8-bit timestamp covers
//   timestamp wrap. Inputs change on the falling edge and outputs are
//   sampled on the falling edge, half a cycle away from the active edge.
module tb_trigger_recorder;

  localparam int TS_W   = 32;
  localparam int EVT_W  = 24;
  localparam int RW     = 2 + EVT_W + TS_W;
  localparam int TS8_W  = 8;
  localparam int RW8    = 2 + EVT_W + TS8_W;

  logic             clk;
  logic             rst;
  logic             l1a, pl1a, align, delta, rd_en;
  logic             rec_valid;
  logic [RW-1:0]    rec_data;
  logic             fifo_full;
  logic [15:0]      ovf_cnt;
  logic [EVT_W-1:0] evt_num;

  logic             l1a8, pl1a8, align8, delta8, rd_en8;
  logic             rec_valid8;
  logic [RW8-1:0]   rec_data8;
  logic             fifo_full8;
  logic [15:0]      ovf_cnt8;
  logic [EVT_W-1:0] evt_num8;

  int tests_run;
  int tests_failed;

  trigger_recorder #(.TS_W(TS_W), .EVT_W(EVT_W), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .l1a       (l1a),
    .pl1a      (pl1a),
    .align     (align),
    .delta     (delta),
    .rd_en     (rd_en),
    .rec_valid (rec_valid),
    .rec_data  (rec_data),
    .fifo_full (fifo_full),
    .ovf_cnt   (ovf_cnt),
    .evt_num   (evt_num)
  );

  trigger_recorder #(.TS_W(TS8_W), .EVT_W(EVT_W), .AW(4)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .l1a       (l1a8),
    .pl1a      (pl1a8),
    .align     (align8),
    .delta     (delta8),
    .rd_en     (rd_en8),
    .rec_valid (rec_valid8),
    .rec_data  (rec_data8),
    .fifo_full (fifo_full8),
    .ovf_cnt   (ovf_cnt8),
    .evt_num   (evt_num8)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset for two cycles and release on a falling edge; the visible
  // timestamp is 0 at the release point.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rec_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rec_valid: got %b expected 0", rec_valid);
    end
    tests_run++;
    if (fifo_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_fifo_full: got %b expected 0", fifo_full);
    end
    tests_run++;
    if (rec_data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rec_data: got %h expected 0", rec_data);
    end
    tests_run++;
    if (ovf_cnt !== 16'd0 || evt_num !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counters: got ovf %h evt %h expected 0 0", ovf_cnt, evt_num);
    end
    tests_run++;
    if (rec_valid8 !== 1'b0 || evt_num8 !== '0 || ovf_cnt8 !== 16'd0 || fifo_full8 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dut8: got valid %b evt %h ovf %h full %b expected all 0",
               rec_valid8, evt_num8, ovf_cnt8, fifo_full8);
    end
  endtask

  // Ten idle cycles after release, then l1a -> record {00, 0, 10}.
  task automatic test_first_l1a();
    logic [RW-1:0] exp;
    do_reset();
    repeat (10) @(negedge clk);
    l1a = 1'b1;
    @(negedge clk);
    l1a = 1'b0;
    exp = {2'b00, 24'd0, 32'd10};
    tests_run++;
    if (rec_valid !== 1'b1 || rec_data !== exp) begin
      tests_failed++;
      $display("[TB] FAIL first_l1a_record: got valid %b data %h expected 1 %h", rec_valid, rec_data, exp);
    end
    tests_run++;
    if (evt_num !== 24'd1) begin
      tests_failed++;
      $display("[TB] FAIL first_l1a_evt: got %0d expected 1", evt_num);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    tests_run++;
    if (rec_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_l1a_pop: got valid %b expected 0", rec_valid);
    end
  endtask

  // Align at timestamp 500 then pl1a when the timestamp reads 3.
  task automatic test_align_pl1a();
    logic [RW-1:0] exp;
    do_reset();
    repeat (5) @(negedge clk);
    l1a = 1'b1;
    @(negedge clk);
    l1a = 1'b0;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (493) @(negedge clk);
    align = 1'b1;
    @(negedge clk);
    align = 1'b0;
    tests_run++;
    if (rec_valid !== 1'b0 || evt_num !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL align_clears: got valid %b evt %0d expected 0 0", rec_valid, evt_num);
    end
    repeat (3) @(negedge clk);
    pl1a = 1'b1;
    @(negedge clk);
    pl1a = 1'b0;
    exp = {2'b01, 24'd0, 32'd3};
    tests_run++;
    if (rec_valid !== 1'b1 || rec_data !== exp) begin
      tests_failed++;
      $display("[TB] FAIL align_pl1a_record: got valid %b data %h expected 1 %h", rec_valid, rec_data, exp);
    end
    tests_run++;
    if (evt_num !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL align_pl1a_evt: got %0d expected 0", evt_num);
    end
  endtask

  // 17 back-to-back l1a with no reads: 16 stored, one dropped.
  task automatic test_fill_overflow();
    logic [RW-1:0] exp;
    do_reset();
    l1a = 1'b1;
    repeat (17) @(negedge clk);
    l1a = 1'b0;
    tests_run++;
    if (fifo_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fill_full: got %b expected 1", fifo_full);
    end
    tests_run++;
    if (ovf_cnt !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL fill_ovf: got %0d expected 1", ovf_cnt);
    end
    tests_run++;
    if (evt_num !== 24'd17) begin
      tests_failed++;
      $display("[TB] FAIL fill_evt: got %0d expected 17", evt_num);
    end
    exp = {2'b00, 24'd0, 32'd0};
    tests_run++;
    if (rec_data !== exp) begin
      tests_failed++;
      $display("[TB] FAIL fill_head: got %h expected %h", rec_data, exp);
    end
  endtask

  // Continues from a full FIFO (timestamp 17, evt 17): push and pop together,
  // then drain and check every record in order.
  task automatic test_full_pop_push();
    logic [RW-1:0] exp;
    rd_en = 1'b1;
    l1a   = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    l1a   = 1'b0;
    tests_run++;
    if (fifo_full !== 1'b1 || ovf_cnt !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL fullpp_state: got full %b ovf %0d expected 1 1", fifo_full, ovf_cnt);
    end
    tests_run++;
    if (evt_num !== 24'd18) begin
      tests_failed++;
      $display("[TB] FAIL fullpp_evt: got %0d expected 18", evt_num);
    end
    for (int i = 0; i < 16; i++) begin
      if (i < 15) exp = {2'b00, 24'(i + 1), 32'(i + 1)};
      else        exp = {2'b00, 24'd17, 32'd17};
      tests_run++;
      if (rec_valid !== 1'b1 || rec_data !== exp) begin
        tests_failed++;
        $display("[TB] FAIL drain_%0d: got valid %b data %h expected 1 %h", i, rec_valid, rec_data, exp);
      end
      rd_en = 1'b1;
      @(negedge clk);
    end
    rd_en = 1'b0;
    tests_run++;
    if (rec_valid !== 1'b0 || fifo_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drain_empty: got valid %b full %b expected 0 0", rec_valid, fifo_full);
    end
  endtask

  // Priority among simultaneous triggers and push+pop on a partly-full FIFO.
  task automatic test_priority();
    logic [RW-1:0] exp;
    do_reset();
    l1a = 1'b1; pl1a = 1'b1; delta = 1'b1;
    @(negedge clk);
    l1a = 1'b0;
    exp = {2'b00, 24'd0, 32'd0};
    tests_run++;
    if (rec_data !== exp || evt_num !== 24'd1) begin
      tests_failed++;
      $display("[TB] FAIL prio_l1a: got data %h evt %0d expected %h 1", rec_data, evt_num, exp);
    end
    rd_en = 1'b1;
    @(negedge clk);
    pl1a = 1'b0; rd_en = 1'b0;
    exp = {2'b01, 24'd1, 32'd1};
    tests_run++;
    if (rec_valid !== 1'b1 || rec_data !== exp || evt_num !== 24'd1) begin
      tests_failed++;
      $display("[TB] FAIL prio_pl1a_pushpop: got valid %b data %h evt %0d expected 1 %h 1",
               rec_valid, rec_data, evt_num, exp);
    end
    @(negedge clk);
    delta = 1'b0;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    exp = {2'b10, 24'd1, 32'd2};
    tests_run++;
    if (rec_valid !== 1'b1 || rec_data !== exp) begin
      tests_failed++;
      $display("[TB] FAIL prio_delta_order: got valid %b data %h expected 1 %h", rec_valid, rec_data, exp);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    tests_run++;
    if (rec_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL prio_empty: got valid %b expected 0", rec_valid);
    end
  endtask

  // align beats l1a; reads on an empty FIFO do nothing.
  task automatic test_align_l1a();
    logic [RW-1:0] exp;
    do_reset();
    l1a = 1'b1;
    @(negedge clk);
    l1a = 1'b0;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    align = 1'b1;
    l1a   = 1'b1;
    @(negedge clk);
    align = 1'b0;
    l1a   = 1'b0;
    tests_run++;
    if (rec_valid !== 1'b0 || evt_num !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL align_l1a: got valid %b evt %0d expected 0 0", rec_valid, evt_num);
    end
    delta = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    delta = 1'b0;
    rd_en = 1'b0;
    exp = {2'b10, 24'd0, 32'd0};
    tests_run++;
    if (rec_valid !== 1'b1 || rec_data !== exp) begin
      tests_failed++;
      $display("[TB] FAIL align_ts_zero: got valid %b data %h expected 1 %h", rec_valid, rec_data, exp);
    end
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    tests_run++;
    if (rec_valid !== 1'b0 || fifo_full !== 1'b0 || ovf_cnt !== 16'd0 || evt_num !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL empty_read: got valid %b full %b ovf %0d evt %0d expected 0 0 0 0",
               rec_valid, fifo_full, ovf_cnt, evt_num);
    end
  endtask

  // 8-bit timestamp: records taken at 255 and at the following 0.
  task automatic test_ts_wrap();
    logic [RW8-1:0] exp;
    do_reset();
    repeat (255) @(negedge clk);
    delta8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    delta8 = 1'b0;
    exp = {2'b10, 24'd0, 8'hFF};
    tests_run++;
    if (rec_valid8 !== 1'b1 || rec_data8 !== exp) begin
      tests_failed++;
      $display("[TB] FAIL wrap_ff: got valid %b data %h expected 1 %h", rec_valid8, rec_data8, exp);
    end
    rd_en8 = 1'b1;
    @(negedge clk);
    rd_en8 = 1'b0;
    exp = {2'b10, 24'd0, 8'h00};
    tests_run++;
    if (rec_valid8 !== 1'b1 || rec_data8 !== exp) begin
      tests_failed++;
      $display("[TB] FAIL wrap_00: got valid %b data %h expected 1 %h", rec_valid8, rec_data8, exp);
    end
  endtask

  // Reset asserted with five records queued clears everything at once.
  task automatic test_reset_midstream();
    logic [RW-1:0] exp;
    do_reset();
    l1a = 1'b1;
    repeat (5) @(negedge clk);
    l1a = 1'b0;
    tests_run++;
    if (rec_valid !== 1'b1 || evt_num !== 24'd5) begin
      tests_failed++;
      $display("[TB] FAIL mid_prefill: got valid %b evt %0d expected 1 5", rec_valid, evt_num);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (rec_valid !== 1'b0 || rec_data !== '0 || fifo_full !== 1'b0 ||
        evt_num !== '0 || ovf_cnt !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got valid %b data %h full %b evt %0d ovf %0d expected all 0",
               rec_valid, rec_data, fifo_full, evt_num, ovf_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    l1a = 1'b1;
    @(negedge clk);
    l1a = 1'b0;
    exp = {2'b00, 24'd0, 32'd2};
    tests_run++;
    if (rec_valid !== 1'b1 || rec_data !== exp) begin
      tests_failed++;
      $display("[TB] FAIL mid_restart: got valid %b data %h expected 1 %h", rec_valid, rec_data, exp);
    end
  endtask

  // Test sequence
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    l1a   = 1'b0; pl1a  = 1'b0; align  = 1'b0; delta  = 1'b0; rd_en  = 1'b0;
    l1a8  = 1'b0; pl1a8 = 1'b0; align8 = 1'b0; delta8 = 1'b0; rd_en8 = 1'b0;

    test_reset();
    test_first_l1a();
    test_align_pl1a();
    test_fill_overflow();
    test_full_pop_push();
    test_priority();
    test_align_l1a();
    test_ts_wrap();
    test_reset_midstream();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
